// File: rtl/load_store_unit.sv
// load_store_unit
// Sequential load/store front-end between the execute stage and a word-wide
// data_memory (combinational read, posedge full-word write). One request is
// handled at a time. Sub-word stores use read-modify-write because the memory
// only writes whole words. Loads are lane-selected and sign/zero-extended.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W requests are rejected with resp_err
//   undefined : misaligned H/HU/W requests align down and proceed normally
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_we                 1 = store, 0 = load
//   req_funct3             RV32I size code (B/H/W/BU/HU)
//   req_addr               byte address
//   req_wdata              right-aligned store data
//   resp_valid             one-cycle completion pulse
//   resp_rdata             extended load data (0 for stores and errors)
//   resp_err               request rejected, no memory write
//   mem_addr/mem_we/mem_wdata/mem_rdata   data_memory interface
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t            state, state_nxt;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        accept;
    logic        illegal_f3;
    logic        out_of_range;
    logic        misaligned;
    logic        req_error;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign accept = req_valid && (state == IDLE);

    // Error decode works on the live request since it is only used at accept.
    assign illegal_f3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
    assign out_of_range = (req_addr >= ADDR_W'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif
    assign req_error = illegal_f3 || out_of_range || misaligned;

    // Outputs decoded from state only: mem_we drops the instant reset
    // forces IDLE, so a partially prepared word is never written.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};

    // Load lane selection and extension from the latched size code.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lane_b    = mem_rdata[7:0];
        lane_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (addr_q[1:0])
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            2'd3:    lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        case (funct3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'd0, lane_b};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    // Sub-word store merge into the word currently held in memory.
    always_comb begin
        merged = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_error)                      state_nxt = RESP;
                    else if (!req_we)                   state_nxt = LOAD;
                    else if (req_funct3[1:0] == 2'b10)  state_nxt = WRITE;
                    else                                state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_error) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                RMW_RD: mem_wdata <= merged;
                WRITE: begin
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255] = '{default: 32'd0};

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    // data_memory model: combinational read, posedge word write
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    load_store_unit #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err,
                                input int lat, input int wes);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_we = wes;
        return v;
    endfunction

    task automatic run(input vec_t v);
        exp_t e;
        int   wes = 0;
        int   lat = 0;
        bit   got = 0;
        bit   ready_bad = 0;
        @(negedge clk);
        check({v.name, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.we = v.exp_we;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the latched request must be used.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (resp_valid) begin
                got = 1;
                lat = c;
                break;
            end
            if (req_ready) ready_bad = 1;
        end
        e = sb.pop_front();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: no resp_valid within 8 cycles", v.name);
            return;
        end
        check({v.name, ".latency"},    32'(lat), 32'(e.lat));
        check({v.name, ".rdata"},      resp_rdata, e.rdata);
        check({v.name, ".err"},        32'(resp_err), 32'(e.err));
        check({v.name, ".mem_we_cnt"}, 32'(wes), 32'(e.we));
        check({v.name, ".busy_ready"}, 32'(ready_bad), 32'd0);
        check({v.name, ".resp_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({v.name, ".pulse_end"},  32'(resp_valid), 32'd0);
        check({v.name, ".rdata_hold"}, resp_rdata, e.rdata);
    endtask

    initial begin
        vecs.push_back(mk("sw_preload", 1, 3'b010, 32'h10, 32'h8899AABB, 0, 0, 2, 1));
        vecs.push_back(mk("lb_13",  0, 3'b000, 32'h13, 0, 32'hFFFFFF88, 0, 2, 0));
        vecs.push_back(mk("lbu_13", 0, 3'b100, 32'h13, 0, 32'h00000088, 0, 2, 0));
        vecs.push_back(mk("lh_12",  0, 3'b001, 32'h12, 0, 32'hFFFF8899, 0, 2, 0));
        vecs.push_back(mk("lhu_10", 0, 3'b101, 32'h10, 0, 32'h0000AABB, 0, 2, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_12_mis", 0, 3'b010, 32'h12, 0, 32'h0, 1, 1, 0));
`else
        vecs.push_back(mk("lw_12_mis", 0, 3'b010, 32'h12, 0, 32'h8899AABB, 0, 2, 0));
`endif
        vecs.push_back(mk("sb_11",  1, 3'b000, 32'h11, 32'h123456CC, 0, 0, 3, 1));
        vecs.push_back(mk("lw_sb",  0, 3'b010, 32'h10, 0, 32'h8899CCBB, 0, 2, 0));
        vecs.push_back(mk("sh_12",  1, 3'b001, 32'h12, 32'h0000BEEF, 0, 0, 3, 1));
        vecs.push_back(mk("lw_sh",  0, 3'b010, 32'h10, 0, 32'hBEEFCCBB, 0, 2, 0));
        vecs.push_back(mk("lh_10",  0, 3'b001, 32'h10, 0, 32'hFFFFCCBB, 0, 2, 0));
        vecs.push_back(mk("lb_12",  0, 3'b000, 32'h12, 0, 32'hFFFFFFEF, 0, 2, 0));
        vecs.push_back(mk("lbu_11", 0, 3'b100, 32'h11, 0, 32'h000000CC, 0, 2, 0));
        vecs.push_back(mk("sw_20",  1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0, 2, 1));
        vecs.push_back(mk("lw_20",  0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 2, 0));
        vecs.push_back(mk("ld_f3_011", 0, 3'b011, 32'h20, 0, 0, 1, 1, 0));
        vecs.push_back(mk("sw_oob",    1, 3'b010, 32'h400, 32'h11111111, 0, 1, 1, 0));
        vecs.push_back(mk("ld_f3_110", 0, 3'b110, 32'h10, 0, 0, 1, 1, 0));
        vecs.push_back(mk("lw_after_err", 0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 2, 0));
        vecs.push_back(mk("sb_3ff",  1, 3'b000, 32'h3FF, 32'hFFFFFF5A, 0, 0, 3, 1));
        vecs.push_back(mk("lbu_3ff", 0, 3'b100, 32'h3FF, 0, 32'h0000005A, 0, 2, 0));
        vecs.push_back(mk("lw_3fc",  0, 3'b010, 32'h3FC, 0, 32'h5A000000, 0, 2, 0));

        // Reset state
        #12;
        check("rst.req_ready",  32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err",   32'(resp_err), 32'd0);
        check("rst.mem_we",     32'(mem_we), 32'd0);
        check("rst.mem_addr",   mem_addr, 32'd0);
        check("rst.mem_wdata",  mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // Reset asserted during WRITE of an SB to word 0x10
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h11; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);                 // RMW_RD
        @(negedge clk);                 // WRITE
        check("mid_rst.we_before", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst.mem_we",     32'(mem_we), 32'd0);
        check("mid_rst.req_ready",  32'(req_ready), 32'd1);
        check("mid_rst.resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst.resp_rdata", resp_rdata, 32'd0);
        check("mid_rst.resp_err",   32'(resp_err), 32'd0);
        check("mid_rst.mem_addr",   mem_addr, 32'd0);
        check("mid_rst.mem_wdata",  mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst.word_10", mem[4], 32'hBEEFCCBB);
        @(negedge clk);
        rst_n = 1'b1;
        run(mk("lw_after_rst", 0, 3'b010, 32'h10, 0, 32'hBEEFCCBB, 0, 2, 0));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequential load/store front-end between the core's execute stage and data_memory (word-addressed, combinational read, posedge word write).
- Accepts one RV32I load/store request at a time.
- Handles byte/halfword/word sizing, load sign/zero extension, and read-modify-write for sub-word stores, since data_memory only writes full words.
- Returns load data or store completion to the writeback stage.

Parameters:
ADDR_W, 32, width of core request address and mem_addr.
MEM_BYTES, 1024, size of the attached data_memory in bytes; a request with addr >= MEM_BYTES is out of range.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores and errors)
resp_err  output  1  request rejected with no memory write; valid with resp_valid
mem_addr  output  ADDR_W  to data_memory address
mem_we  output  1  to data_memory MemWrite
mem_wdata  output  32  to data_memory write_data
mem_rdata  input  32  from data_memory read_data (combinational)

Behaviour:
- Reset values: FSM in IDLE; all latched request registers 0; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Handshake: request accepted on a rising edge with req_valid && req_ready. All request fields latch; later input changes are ignored until the next accept.
- mem_addr = latched address with bits [1:0] forced to 00.
- mem_we is a decoded output of the FSM state only, never of inputs.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - Accepted request with error condition -> RESP, resp_err=1.
  - Accepted load -> LOAD.
  - Accepted SW -> WRITE, mem_wdata=req_wdata.
  - Accepted SB/SH -> RMW_RD.
- LOAD: on the edge, sample mem_rdata, select the lane, extend, and register into resp_rdata. -> RESP.
  - Lane select: byte = addr[1:0], half = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W unchanged.
- RMW_RD: on the edge, merge new bytes into sampled mem_rdata and register the result in mem_wdata. -> WRITE.
  - Byte: req_wdata[7:0] replaces bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half: req_wdata[15:0] replaces bits [16*addr[1]+15 : 16*addr[1]].
- WRITE: mem_we=1 for exactly this one cycle. -> RESP.
- RESP: resp_valid=1 for one cycle; resp_rdata/resp_err held stable. -> IDLE.
  - resp_rdata/resp_err hold their values after RESP until the next RESP.
  - req_ready=0 in every state except IDLE; no back-to-back overlap.
- Latency, counting from the accept edge to the resp_valid cycle:
  - Load: resp_valid in the 2nd cycle after accept.
  - SW: 2nd cycle.
  - SB/SH: 3rd cycle.
  - Error: 1st cycle.
- Error conditions (checked at accept): funct3 in {011,110,111}, or addr >= MEM_BYTES. Result: resp_err=1, resp_rdata=0, mem_we never asserted.
- Misalignment (H at addr[0]=1, W at addr[1:0]!=00) is handled per Optional Feature.
- Byte stores at any offset are always legal.
- Reset mid-operation (any state): asynchronous return to IDLE. mem_we drops immediately (combinational from state), so no partial word is written. Pending response is discarded.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: misaligned H/HU/W requests are error conditions (resp_err=1, resp_rdata=0, no memory access, resp_valid in the 1st cycle after accept).
- Undefined: misalignment is ignored. Address aligns down per size (H uses addr[1], W uses word address) and the access proceeds normally with resp_err=0.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB 0x13 -> resp_rdata=0xFFFFFF88. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. Each resp_valid in the 2nd cycle after accept; req_ready low until back in IDLE.
- SB 0x11, wdata 0x123456CC -> mem_we high exactly 1 cycle, word 0x10 = 0x8899CCBB, resp_valid in the 3rd cycle. Then SH 0x12, wdata 0x0000BEEF -> word = 0xBEEFCCBB.
- SW 0x20, wdata 0xDEADBEEF, then LW 0x20 -> 0xDEADBEEF. Store response has resp_rdata=0, resp_err=0.
- funct3=011 load, and SW to addr 0x400 (=MEM_BYTES) -> resp_err=1, resp_rdata=0, mem_we never high, resp_valid in the 1st cycle after accept.
- LW 0x12 with word 0x10 = 0x8899AABB:
  - MISALIGN_TRAP_EN defined -> resp_err=1, no access.
  - Undefined -> resp_rdata=0x8899AABB, resp_err=0.
- SB 0x11 with rst_n pulled low during WRITE -> mem_we falls the same cycle, word 0x10 unchanged, outputs at reset values. First request after release is accepted normally.
